// File: rtl/up_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl_if
//   Bundles the control inputs and status outputs of up_counter_ctrl.
//   Clock and reset are kept as plain ports on the counter itself.
//
//   master : drives en, sclr, load, load_val, limit, mode, start;
//            observes count, tc, wrap, busy, done
//   slave  : the counter side (mirror of master)
// ---------------------------------------------------------------------------
interface up_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             sclr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output en, sclr, load, load_val, limit, mode, start,
        input  count, tc, wrap, busy, done
    );

    modport slave (
        input  en, sclr, load, load_val, limit, mode, start,
        output count, tc, wrap, busy, done
    );
endinterface

// File: rtl/up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl
//   Programmable up counter counting from 0 toward a runtime terminal value.
//   Modes: 00/11 free-run wrap, 01 saturate, 10 one-shot.
//
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous reset, active low
//     bus   : up_counter_ctrl_if.slave
//               en       count enable
//               sclr     synchronous clear (highest priority)
//               load     synchronous parallel load of load_val
//               load_val value written to count on load
//               limit    terminal value, sampled every cycle
//               mode     counting mode
//               start    one-shot trigger (mode 10 only)
//               count    current count (registered)
//               tc       count == limit (combinational)
//               wrap     registered 1-cycle pulse when count wrapped to 0
//               busy     one-shot running
//               done     one-shot completed (level)
//
//   One-shot FSM:
//     state   | meaning
//     --------+-----------------------------------------------------------
//     ST_IDLE | not running; count holds, start launches a run from 0
//     ST_RUN  | counting toward limit on enabled cycles; start ignored
//     ST_DONE | limit reached; count holds, start relaunches from 0
// ---------------------------------------------------------------------------
module up_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    up_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             busy_q;
    logic             done_q;

    logic             mode_oneshot;
    logic             mode_sat;
    logic             at_term;
    logic [WIDTH-1:0] count_inc;

    // mode 11 is reserved and falls through to wrap behaviour
    assign mode_oneshot = (bus.mode == 2'b10);
    assign mode_sat     = (bus.mode == 2'b01);

    // >= rather than == so a count left above limit by a load or a lowered
    // limit still terminates instead of running on to natural overflow
    assign at_term   = (count_q >= bus.limit);

    // only used when count < limit, so it can never overflow
    assign count_inc = count_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            count_q <= CNT_ZERO;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;

            if (bus.sclr) begin
                state   <= ST_IDLE;
                count_q <= CNT_ZERO;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (bus.load) begin
                // FSM state untouched: a load during RUN lets the one-shot
                // carry on from the loaded value
                count_q <= bus.load_val;
            end else if (mode_oneshot) begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            state   <= ST_RUN;
                            count_q <= CNT_ZERO;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (bus.en) begin
                            if (at_term) begin
                                state  <= ST_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                count_q <= count_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                endcase
            end else begin
                // leaving one-shot mode drops the FSM back to idle; the
                // counter itself continues under the new mode right away
                state  <= ST_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b0;

                if (bus.en) begin
                    if (mode_sat) begin
                        if (!at_term) begin
                            count_q <= count_inc;
                        end
                    end else begin
                        if (at_term) begin
                            count_q <= CNT_ZERO;
                            wrap_q  <= 1'b1;
                        end else begin
                            count_q <= count_inc;
                        end
                    end
                end
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = (count_q == bus.limit);
    assign bus.wrap  = wrap_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_up_counter_ctrl
//   Scoreboard bench for up_counter_ctrl. Each stimulus cycle updates an
//   integer reference model and queues the expected outputs; a monitor pops
//   and compares after every rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_up_counter_ctrl;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk;
    logic rst;

    up_counter_ctrl_if #(.WIDTH(W)) bus ();

    up_counter_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected word: {count, tc, wrap, busy, done}
    typedef logic [W+3:0] exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // reference model: count as an integer, one-shot phase as a name
    int    m_cnt   = 0;
    string m_phase = "idle";
    int    m_wrap  = 0;

    function automatic exp_t pack_exp(input int cnt, input int lim, input int wr,
                                      input string ph);
        exp_t e;
        e[W+3:4] = W'(cnt);
        e[3]     = (cnt == lim);
        e[2]     = (wr != 0);
        e[1]     = (ph == "run");
        e[0]     = (ph == "done");
        return e;
    endfunction

    // Apply one cycle of spec behaviour to the model.
    task automatic model_step(input bit en, input bit sclr, input bit load,
                              input int lv, input int lim, input int md,
                              input bit st);
        m_wrap = 0;
        if (sclr) begin
            m_cnt   = 0;
            m_phase = "idle";
        end else if (load) begin
            m_cnt = lv;
        end else if (md == 2) begin
            if (m_phase == "run") begin
                if (en) begin
                    if (m_cnt >= lim) m_phase = "done";
                    else              m_cnt   = m_cnt + 1;
                end
            end else if (st) begin
                m_phase = "run";
                m_cnt   = 0;
            end
        end else begin
            m_phase = "idle";
            if (en) begin
                if (md == 1) begin
                    m_cnt = (m_cnt < lim) ? m_cnt + 1 : m_cnt;
                end else if (m_cnt >= lim) begin
                    m_cnt  = 0;
                    m_wrap = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expectation.
    task automatic step(input bit en, input bit sclr, input bit load,
                        input int lv, input int lim, input int md, input bit st);
        @(negedge clk);
        bus.en       = en;
        bus.sclr     = sclr;
        bus.load     = load;
        bus.load_val = W'(lv);
        bus.limit    = W'(lim);
        bus.mode     = 2'(md);
        bus.start    = st;
        model_step(en, sclr, load, lv, lim, md, st);
        exp_q.push_back(pack_exp(m_cnt, lim, m_wrap, m_phase));
    endtask

    task automatic check_now(input string name, input exp_t want);
        exp_t got;
        got = {bus.count, bus.tc, bus.wrap, bus.busy, bus.done};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got {count,tc,wrap,busy,done}=%b want %b", name, got, want);
        end
    endtask

    // monitor: outputs are valid every cycle; compare well after the edge
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t want;
            exp_t got;
            want = exp_q.pop_front();
            got  = {bus.count, bus.tc, bus.wrap, bus.busy, bus.done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL scoreboard t=%0t: got {count,tc,wrap,busy,done}=%b want %b",
                         $time, got, want);
            end
        end
    end

    initial begin
        int lim;
        int md;

        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.sclr     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.limit    = '0;
        bus.mode     = 2'b00;
        bus.start    = 1'b0;

        #3;
        // limit=0 while in reset, so tc=1 with count=0
        check_now("reset_state", pack_exp(0, 0, 0, "idle"));
        #4 rst = 1'b1;

        // free-run wrap, limit 5
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 5, 0, 0);

        // saturate at all-ones
        step(0, 1, 0, 0, MAX, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, MAX, 1, 0);

        // one-shot, limit 3
        step(0, 1, 0, 0, 3, 2, 0);
        step(1, 0, 0, 0, 3, 2, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 3, 2, 0);
        step(1, 0, 0, 0, 3, 2, 1);                       // restart from DONE
        step(1, 0, 0, 0, 3, 2, 0);
        step(1, 0, 0, 0, 3, 2, 1);                       // ignored in RUN
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 3, 2, 0);

        // one-shot with limit 0
        step(0, 0, 0, 0, 0, 2, 1);
        step(1, 0, 0, 0, 0, 2, 0);
        step(1, 0, 0, 0, 0, 2, 0);

        // out-of-range load then wrap; sclr beats load
        step(0, 1, 0, 0, 6, 0, 0);
        step(0, 0, 1, 12, 6, 0, 0);
        step(1, 0, 0, 0, 6, 0, 0);
        step(1, 0, 0, 0, 6, 0, 0);
        step(1, 1, 1, 9, 6, 0, 1);

        // enable gating
        step(1, 0, 0, 0, 9, 0, 0);
        step(0, 0, 0, 0, 9, 0, 0);
        step(1, 0, 0, 0, 9, 0, 0);
        step(0, 0, 0, 0, 9, 0, 0);

        // wrap mode with limit 0: wrap every enabled cycle
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 3, 0);

        // async reset in the middle of a one-shot run at count 2
        step(0, 1, 0, 0, 7, 2, 0);
        step(1, 0, 0, 0, 7, 2, 1);
        step(1, 0, 0, 0, 7, 2, 0);
        step(1, 0, 0, 0, 7, 2, 0);
        @(posedge clk);
        #3;
        check_now("run_before_reset", pack_exp(2, 7, 0, "run"));
        rst = 1'b0;
        #1;
        check_now("async_reset", pack_exp(0, 7, 0, "idle"));
        m_cnt   = 0;
        m_phase = "idle";
        m_wrap  = 0;
        rst     = 1'b1;

        // randomized traffic
        lim = $urandom_range(0, MAX);
        md  = $urandom_range(0, 3);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) lim = $urandom_range(0, MAX);
            if ($urandom_range(0, 11) == 0) md  = $urandom_range(0, 3);
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 25) == 0),
                 $urandom_range(0, MAX),
                 lim, md,
                 ($urandom_range(0, 7) == 0));
        end

        // let the monitor drain; anything left over is a lost response
        repeat (3) @(posedge clk);
        #4;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
